// File: rtl/cycle_mon_pkg.sv
// Purpose: shared types and constants for the wrap-counter period monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cycle_mon_pkg;

  // Default counter geometry, matching the wrap counter this block observes.
  localparam int W_DEFAULT      = 11;
  localparam int N_INIT_DEFAULT = 200;

  // Monitor FSM states; the encoding is exported on state_o for debug.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  // Fault codes, recorded once on the first violation.
  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_STEP  = 2'b01;
  localparam logic [1:0] FC_OVER  = 2'b10;
  localparam logic [1:0] FC_LIMIT = 2'b11;

endpackage

// File: rtl/count_predictor.sv
// Purpose: predicts the wrap counter's next count from last cycle's sampled c/n/selector.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module count_predictor #(
  parameter int W = 11
) (
  input  logic [W-1:0] c_q,
  input  logic [W-1:0] n_q,
  input  logic         sel_q,
  output logic [W-1:0] c_exp
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Hold when not advancing, restart at 1 after reaching the limit, else step by one (mod 2^W).
  always_comb begin
    c_exp = c_q;
    if (sel_q) begin
      if (c_q == n_q) begin
        c_exp = ONE;
      end else begin
        c_exp = c_q + ONE;
      end
    end
  end

endmodule

// File: rtl/cycle_period_monitor.sv
// Purpose: passive checker for the wrap counter; pulses per period, counts periods, latches first fault.
// Latency: verdicts and wrap pulse are registered, visible 1 cycle after the sampled c/n/selector.
// Backpressure: none; observes only and never stalls the counter.
module cycle_period_monitor
  import cycle_mon_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int CNT_W  = 16,
  parameter int N_INIT = N_INIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selector,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     n,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_count,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [1:0]       state_o
);

  localparam logic [W-1:0]     N_INIT_W = W'(N_INIT);
  localparam logic [W-1:0]     ZERO_W   = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  mon_state_t   state;
  logic [W-1:0] c_q;
  logic [W-1:0] n_q;
  logic         sel_q;
  logic [W-1:0] c_exp;
  logic [1:0]   chk_code;
  logic         wrap_hit;

  count_predictor #(.W(W)) u_pred (
    .c_q   (c_q),
    .n_q   (n_q),
    .sel_q (sel_q),
    .c_exp (c_exp)
  );

  // Tracking checks in priority order: over-limit, then limit change, then bad step.
  always_comb begin
    chk_code = FC_NONE;
    if (c > n) begin
      chk_code = FC_OVER;
    end else if (n != n_q) begin
      chk_code = FC_LIMIT;
    end else if (c != c_exp) begin
      chk_code = FC_STEP;
    end
  end

  // A period completes when the counter advances at its limit; any failing check suppresses it.
  assign wrap_hit = selector && (c == n) && (chk_code == FC_NONE);

  assign state_o = state;

  // Sample registers, monitor FSM, sticky fault latch and saturating period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      c_q        <= '0;
      n_q        <= N_INIT_W;
      sel_q      <= 1'b0;
    end else begin
      c_q   <= c;
      n_q   <= n;
      sel_q <= selector;
      case (state)
        INIT: begin
          wrap_pulse <= 1'b0;
          if ((c == ZERO_W) && (n == N_INIT_W)) begin
            state <= TRACK;
          end else begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= FC_LIMIT;
          end
        end
        TRACK: begin
          if (chk_code != FC_NONE) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= chk_code;
            wrap_pulse <= 1'b0;
          end else begin
            wrap_pulse <= wrap_hit;
            if (wrap_hit && (wrap_count != CNT_MAX)) begin
              wrap_count <= wrap_count + CNT_ONE;
            end
          end
        end
        FAULT: begin
          // Sticky until reset: pulse forced low, counter and code frozen.
          wrap_pulse <= 1'b0;
        end
        default: begin
          // Unused encoding: treat as a corrupted monitor and park in FAULT.
          state      <= FAULT;
          wrap_pulse <= 1'b0;
          fault      <= 1'b1;
          fault_code <= FC_LIMIT;
        end
      endcase
    end
  end

endmodule
